// File: rtl/bram_regfile_pkg.sv
// Shared types and constants for the BRAM-mapped register file.
// Provides the per-register mode enum and helpers for building mode arrays.
package bram_regfile_pkg;

  typedef enum logic [1:0] {
    REG_RW    = 2'd0,
    REG_RO    = 2'd1,
    REG_W1C   = 2'd2,
    REG_PULSE = 2'd3
  } reg_mode_t;

  localparam int RDLAT_MAX = 2;
  localparam int NREGS_MAX = 64;
  localparam int MIDX_W    = $clog2(NREGS_MAX);

  // Mode arrays are sized for the largest supported file; only the first Nregs entries matter.
  typedef reg_mode_t [NREGS_MAX-1:0] mode_array_t;

  function automatic mode_array_t default_modes();
    mode_array_t m;
    m = '{default: REG_RW};
    return m;
  endfunction

  function automatic mode_array_t with_mode(input mode_array_t m, input int idx,
                                            input reg_mode_t md);
    mode_array_t r;
    logic [MIDX_W-1:0] sel;
    r = m;
    sel = idx[MIDX_W-1:0];
    r[sel] = md;
    return r;
  endfunction

endpackage

// File: rtl/bram_regfile_if.sv
// Native BRAM controller port as seen by the register file.
// en is a single-cycle access strobe with no backpressure: every cycle with en=1 is one
// read plus a write on each byte lane whose we bit is set; there is no ready signal.
interface bram_regfile_if #(
  parameter int Naddr = 4,
  parameter int Ndata = 32
);
  localparam int Nbyte = Ndata / 8;

  logic [Naddr-1:0] addr;
  logic [Ndata-1:0] wr_data;
  logic [Ndata-1:0] rd_data;
  logic             en;
  logic [Nbyte-1:0] we;

  modport master (output addr, output wr_data, output en, output we, input rd_data);
  modport slave  (input addr, input wr_data, input en, input we, output rd_data);

endinterface

// File: rtl/bram_regfile_lane.sv
// One byte lane of one register: RW storage, W1C status or one-cycle pulse, chosen by MODE.
module bram_regfile_lane
  import bram_regfile_pkg::*;
#(
  parameter reg_mode_t  MODE = REG_RW,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic [7:0] set,
  output logic [7:0] q
);

  logic [7:0] q_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_r <= (MODE == REG_RW) ? INIT : 8'h00;
    end else begin
      case (MODE)
        REG_RW:    if (wr) q_r <= wdata;
        // A hardware set in the same cycle as a software clear keeps the bit high.
        REG_W1C:   q_r <= set | (q_r & ~(wr ? wdata : 8'h00));
        REG_PULSE: q_r <= wr ? wdata : 8'h00;
        default:   q_r <= 8'h00;
      endcase
    end
  end

  assign q = q_r;

endmodule

// File: rtl/bram_regfile.sv
// Parametrised register file behind an AXI BRAM controller native port.
// Define BRAM_REGFILE_IRQ_EN to drive irq from the OR of all W1C status bits.
module bram_regfile
  import bram_regfile_pkg::*;
#(
  parameter int                          Naddr    = 4,
  parameter int                          Nregs    = 2 ** Naddr,
  parameter int                          Ndata    = 32,
  parameter int                          Nbyte    = Ndata / 8,
  parameter int                          Rlat     = 1,
  parameter mode_array_t                 reg_mode = default_modes(),
  parameter logic [Nregs-1:0][Ndata-1:0] init_reg = '0
) (
  input  logic                          clk,
  input  logic                          resetn,
  bram_regfile_if.slave                 bus,
  output logic [Nregs-1:0][Ndata-1:0]   reg_val,
  output logic [Nregs-1:0][Ndata-1:0]   pul_val,
  input  logic [Nregs-1:0][Ndata-1:0]   read_val,
  input  logic [Nregs-1:0][Ndata-1:0]   set_val,
  output logic [Nregs-1:0][Ndata-1:0]   sts_val,
  output logic                          irq
);

  localparam int NWORDS = 2 ** Naddr;
  localparam int RLAT   = (Rlat >= RDLAT_MAX) ? RDLAT_MAX : 1;

  // Readback word for every decodable address; unimplemented addresses read as zero.
  logic [NWORDS-1:0][Ndata-1:0] rd_word;
  logic [Ndata-1:0]             rd_mux;
  logic [Ndata-1:0]             rd_q;

  for (genvar i = 0; i < Nregs; i++) begin : g_reg
    logic sel;
    assign sel = bus.en && (bus.addr == Naddr'(i));

    if (reg_mode[i] == REG_RO) begin : g_ro
      assign reg_val[i] = '0;
      assign pul_val[i] = '0;
      assign sts_val[i] = '0;
      assign rd_word[i] = read_val[i];
    end else begin : g_lanes
      logic [Ndata-1:0] q;

      for (genvar b = 0; b < Nbyte; b++) begin : g_lane
        bram_regfile_lane #(
          .MODE (reg_mode[i]),
          .INIT (init_reg[i][8*b +: 8])
        ) u_lane (
          .clk    (clk),
          .resetn (resetn),
          .wr     (sel && bus.we[b]),
          .wdata  (bus.wr_data[8*b +: 8]),
          .set    (set_val[i][8*b +: 8]),
          .q      (q[8*b +: 8])
        );
      end

      assign reg_val[i] = (reg_mode[i] == REG_RW)    ? q : '0;
      assign pul_val[i] = (reg_mode[i] == REG_PULSE) ? q : '0;
      assign sts_val[i] = (reg_mode[i] == REG_W1C)   ? q : '0;
      assign rd_word[i] = (reg_mode[i] == REG_PULSE) ? '0 : q;
    end
  end

  for (genvar i = Nregs; i < NWORDS; i++) begin : g_hole
    assign rd_word[i] = '0;
  end

  // Sampled from pre-edge state, so a read during a write returns the old value.
  assign rd_mux = rd_word[bus.addr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q <= '0;
    end else if (bus.en) begin
      rd_q <= rd_mux;
    end
  end

  if (RLAT == 2) begin : g_rlat2
    logic             rd_v;
    logic [Ndata-1:0] rd_q2;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rd_v  <= 1'b0;
        rd_q2 <= '0;
      end else begin
        rd_v <= bus.en;
        if (rd_v) rd_q2 <= rd_q;
      end
    end

    assign bus.rd_data = rd_q2;
  end else begin : g_rlat1
    assign bus.rd_data = rd_q;
  end

`ifdef BRAM_REGFILE_IRQ_EN
  logic irq_r;

  // sts_val is already zero outside W1C registers, so a flat OR covers exactly the status bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |sts_val;
    end
  end

  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

  // Sink for input bits that only some register modes consume.
  logic unused_inputs;
  assign unused_inputs = ^{read_val, set_val};

endmodule

// File: tb/tb_bram_regfile.sv
// Directed bench for bram_regfile: Rlat=1 and Rlat=2 instances share one stimulus stream
// and are compared every cycle against a word-level model of the register rules.
module tb_bram_regfile;
  import bram_regfile_pkg::*;

  localparam int NA = 4;
  localparam int NR = 12;
  localparam int ND = 32;
  localparam int NB = ND / 8;

  localparam mode_array_t MODES =
    with_mode(with_mode(with_mode(default_modes(), 0, REG_RO), 2, REG_PULSE), 3, REG_W1C);
  localparam logic [NR-1:0][ND-1:0] INIT =
    {224'h0, 32'hA5A50001, 64'h0, 32'h12345678, 32'h0};

`ifdef BRAM_REGFILE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  // ---------------- clock / reset / stimulus signals ----------------
  logic                clk = 1'b0;
  logic                resetn;
  logic [NA-1:0]       addr;
  logic [ND-1:0]       wdata;
  logic                en;
  logic [NB-1:0]       we;
  logic [NR-1:0][ND-1:0] read_val, set_val;
  logic [NR-1:0][ND-1:0] reg1, pul1, sts1, reg2, pul2, sts2;
  logic                irq1, irq2;

  always #5 clk = ~clk;

  bram_regfile_if #(.Naddr(NA), .Ndata(ND)) b1 ();
  bram_regfile_if #(.Naddr(NA), .Ndata(ND)) b2 ();

  assign b1.addr = addr;  assign b1.wr_data = wdata;  assign b1.en = en;  assign b1.we = we;
  assign b2.addr = addr;  assign b2.wr_data = wdata;  assign b2.en = en;  assign b2.we = we;

  bram_regfile #(.Naddr(NA), .Nregs(NR), .Ndata(ND), .Rlat(1),
                 .reg_mode(MODES), .init_reg(INIT)) d1 (
    .clk(clk), .resetn(resetn), .bus(b1), .reg_val(reg1), .pul_val(pul1),
    .read_val(read_val), .set_val(set_val), .sts_val(sts1), .irq(irq1));

  bram_regfile #(.Naddr(NA), .Nregs(NR), .Ndata(ND), .Rlat(2),
                 .reg_mode(MODES), .init_reg(INIT)) d2 (
    .clk(clk), .resetn(resetn), .bus(b2), .reg_val(reg2), .pul_val(pul2),
    .read_val(read_val), .set_val(set_val), .sts_val(sts2), .irq(irq2));

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [NR*ND-1:0] act, input logic [NR*ND-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic reg_mode_t mode_of(input int a);
    case (a)
      0:       return REG_RO;
      2:       return REG_PULSE;
      3:       return REG_W1C;
      default: return REG_RW;
    endcase
  endfunction

  logic [NR-1:0][ND-1:0] m_reg, m_sts, m_pul;
  logic                  m_irq;
  logic [ND-1:0]         e_rd1, e_rd2;
  logic [ND-1:0]         exp_q1[$], exp_q2[$];
  int                    due_q1[$], due_q2[$];
  int                    cyc;

  function automatic logic [ND-1:0] readback(input int a);
    if (a >= NR) return '0;
    case (mode_of(a))
      REG_RO:  return read_val[a];
      REG_RW:  return m_reg[a];
      REG_W1C: return m_sts[a];
      default: return '0;
    endcase
  endfunction

  function automatic logic [ND-1:0] lane_mask(input logic [NB-1:0] w);
    logic [ND-1:0] m;
    for (int b = 0; b < NB; b++) m[8*b +: 8] = {8{w[b]}};
    return m;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NR; i++) m_reg[i] = (mode_of(i) == REG_RW) ? INIT[i] : '0;
      m_sts = '0;
      m_pul = '0;
      m_irq = 1'b0;
      e_rd1 = '0;
      e_rd2 = '0;
      exp_q1.delete(); due_q1.delete();
      exp_q2.delete(); due_q2.delete();
      cyc = 0;
    end else begin
      logic [ND-1:0] rv;
      logic [ND-1:0] mask;
      cyc++;
      m_irq = IRQ_ON && (m_sts != '0);
      if (en) begin
        rv = readback(int'(addr));
        exp_q1.push_back(rv); due_q1.push_back(cyc);
        exp_q2.push_back(rv); due_q2.push_back(cyc + 1);
      end
      while (due_q1.size() > 0 && due_q1[0] <= cyc) begin
        e_rd1 = exp_q1.pop_front();
        void'(due_q1.pop_front());
      end
      while (due_q2.size() > 0 && due_q2[0] <= cyc) begin
        e_rd2 = exp_q2.pop_front();
        void'(due_q2.pop_front());
      end
      mask = lane_mask(we);
      for (int i = 0; i < NR; i++) begin
        logic [ND-1:0] wm;
        wm = (en && int'(addr) == i) ? mask : '0;
        case (mode_of(i))
          REG_RW:    m_reg[i] = (m_reg[i] & ~wm) | (wdata & wm);
          REG_W1C:   m_sts[i] = set_val[i] | (m_sts[i] & ~(wdata & wm));
          REG_PULSE: m_pul[i] = wdata & wm;
          default:   ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("rd_rlat1", b1.rd_data, e_rd1);
    chk("rd_rlat2", b2.rd_data, e_rd2);
    chk("reg_val_1", reg1, m_reg);
    chk("reg_val_2", reg2, m_reg);
    chk("pul_val_1", pul1, m_pul);
    chk("pul_val_2", pul2, m_pul);
    chk("sts_val_1", sts1, m_sts);
    chk("sts_val_2", sts2, m_sts);
    chk("irq_1", irq1, m_irq);
    chk("irq_2", irq2, m_irq);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic acc(input logic [NA-1:0] a, input logic [ND-1:0] d, input logic [NB-1:0] w);
    addr = a; wdata = d; we = w; en = 1'b1;
    tick();
    en = 1'b0; we = '0;
  endtask

  typedef struct { logic [NA-1:0] a; logic [ND-1:0] d; logic [NB-1:0] w; } vec_t;
  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'd1,  32'h11223344, 4'b1111};
    vecs[1] = '{4'd1,  32'h00000000, 4'b0000};
    vecs[2] = '{4'd4,  32'h55667788, 4'b1000};
    vecs[3] = '{4'd3,  32'h000000FF, 4'b0001};
    vecs[4] = '{4'd2,  32'h0000FF00, 4'b0010};
    vecs[5] = '{4'd12, 32'h00000001, 4'b1111};
    vecs[6] = '{4'd4,  32'h00000000, 4'b0000};
    vecs[7] = '{4'd0,  32'h00000000, 4'b0000};
    vecs[8] = '{4'd1,  32'h00000000, 4'b0000};
    vecs[9] = '{4'd11, 32'h0000CAFE, 4'b0011};

    resetn = 1'b1; addr = '0; wdata = '0; en = 1'b0; we = '0;
    read_val = '0; set_val = '0;
    read_val[0] = 32'hCAFEF00D;
    #1 resetn = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_reg1", reg1[1], 32'h12345678);
    chk("rst_reg4", reg2[4], 32'hA5A50001);
    chk("rst_rd", b2.rd_data, 32'h0);
    chk("rst_pul", pul1, '0);
    chk("rst_sts", sts1, '0);
    chk("rst_irq", irq1, 1'b0);
    resetn = 1'b1;
    tick();

    // RW byte-lane write; the same-cycle read returns the pre-write value
    acc(4'd1, 32'hAABBCCDD, 4'b0101);
    chk("rw_val", reg1[1], 32'h12BB56DD);
    chk("rw_rbw", b1.rd_data, 32'h12345678);
    acc(4'd1, 32'h0, 4'b0000);
    chk("rw_rd_lat1", b1.rd_data, 32'h12BB56DD);
    chk("rw_rd_lat2_old", b2.rd_data, 32'h12345678);
    tick();
    chk("rw_rd_lat2", b2.rd_data, 32'h12BB56DD);
    chk("rw_rd_hold", b1.rd_data, 32'h12BB56DD);

    // PULSE register
    acc(4'd2, 32'h00000081, 4'b1111);
    chk("pulse_on", pul1[2], 32'h00000081);
    chk("pulse_on_2", pul2[2], 32'h00000081);
    tick();
    chk("pulse_off", pul1[2], 32'h0);
    acc(4'd2, 32'h0, 4'b0000);
    chk("pulse_rd", b1.rd_data, 32'h0);

    // W1C register with irq
    set_val[3] = 32'h5;
    tick();
    set_val[3] = '0;
    chk("w1c_set", sts1[3], 32'h5);
    chk("w1c_irq_lag", irq1, 1'b0);
    tick();
    chk("w1c_irq", irq1, IRQ_ON);
    acc(4'd3, 32'h1, 4'b1111);
    chk("w1c_clr", sts1[3], 32'h4);
    chk("w1c_rd", b1.rd_data, 32'h5);
    set_val[3] = 32'h4;
    acc(4'd3, 32'h4, 4'b1111);
    set_val[3] = '0;
    chk("w1c_set_wins", sts1[3], 32'h4);
    acc(4'd3, 32'h4, 4'b1111);
    chk("w1c_clr_all", sts1[3], 32'h0);
    tick();
    chk("w1c_irq_off", irq1, 1'b0);

    // RO register and out-of-range addresses
    acc(4'd0, 32'hFFFFFFFF, 4'b1111);
    chk("ro_reg_val", reg1[0], 32'h0);
    chk("ro_rd", b1.rd_data, 32'hCAFEF00D);
    acc(4'd14, 32'hDEADBEEF, 4'b1111);
    chk("oob_rd", b1.rd_data, 32'h0);
    acc(4'd4, 32'h0, 4'b0000);
    chk("init_rd4", b1.rd_data, 32'hA5A50001);

    // back-to-back accesses, one per cycle
    for (int k = 0; k < 10; k++) begin
      addr = vecs[k].a; wdata = vecs[k].d; we = vecs[k].w; en = 1'b1;
      tick();
    end
    en = 1'b0; we = '0;
    tick(); tick();
    chk("b2b_reg1", reg1[1], 32'h11223344);
    chk("b2b_reg4", reg2[4], 32'h55A50001);
    chk("b2b_reg11", reg1[11], 32'h0000CAFE);

    // reset in the middle of a Rlat=2 read
    addr = 4'd1; en = 1'b1; we = '0;
    @(posedge clk);
    #2 resetn = 1'b0;
    en = 1'b0;
    #1;
    chk("midrst_rd2", b2.rd_data, 32'h0);
    chk("midrst_rd1", b1.rd_data, 32'h0);
    chk("midrst_reg1", reg1[1], 32'h12345678);
    tick(); tick();
    resetn = 1'b1;
    tick(); tick(); tick();
    chk("postrst_rd2", b2.rd_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_regfile.md
# bram_regfile

Parametrised register file driven by an AXI BRAM Controller native port; next generation of the team's BRAM-mapped register block. Generalises data width and register count, adds a per-register access mode (read/write, read-only, write-1-to-clear status, self-clearing pulse) and a configurable read latency. Sits outside the IPI block diagram, beside the BRAM controller, so the application sees flat two-dimensional arrays while addresses stay exported in the XSA.

## Interface
- Naddr, 4: register (word) address width.
- Nregs, 2**Naddr: number of implemented registers; Nregs <= 2**Naddr.
- Ndata, 32: data width in bits; multiple of 8, 32 or 64.
- Nbyte, Ndata/8: byte-enable width (derived).
- Rlat, 1: read latency in cycles, 1 or 2.
- reg_mode, all RW: per-register mode array, type reg_mode_t[Nregs].
- init_reg, 0: per-register reset value, RW registers only.

- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- addr  in  Naddr  register address from BRAM controller.
- wr_data  in  Ndata  write data.
- rd_data  out  Ndata  read data.
- en  in  1  access enable.
- we  in  Nbyte  byte write enables.
- reg_val  out  Nregs x Ndata  current RW register values.
- pul_val  out  Nregs x Ndata  one-cycle pulse of bits written 1 to PULSE registers.
- read_val  in  Nregs x Ndata  application values for RO registers.
- set_val  in  Nregs x Ndata  one-cycle hardware set strobes for W1C registers.
- sts_val  out  Nregs x Ndata  current W1C status bits.
- irq  out  1  level interrupt (see Configuration).

## Operation
- Modes: RW — byte-lane writes to reg_val, readback reg_val. RO — writes ignored, readback read_val. W1C — status bit set by set_val, cleared by writing 1 with its byte lane enabled; readback sts_val. PULSE — written 1-bits appear on pul_val for exactly one cycle; readback zero.
- Write qualifies when en=1 and we[b]=1 for lane b; a lane with we[b]=0 is untouched.
- Read occurs whenever en=1 (including write cycles); read value is pre-write state (read-before-write).
- W1C: simultaneous set_val bit and software clear of the same bit: set wins, bit stays 1.
- addr >= Nregs: writes ignored, read returns 0.
- pul_val: all registers' pulse bits are 0 in every cycle without a qualifying PULSE write; bits of other registers/lanes remain 0 during a write.
- reg_val, pul_val, sts_val outputs are zero for register indices whose mode differs from the output's mode.
- Reset (any time, including mid-access): reg_val = init_reg, pul_val = 0, sts_val = 0, rd_data = 0, irq = 0, read pipeline flushed; access in flight is discarded.

## Timing
- Write at edge N: reg_val/sts_val updated after edge N; pul_val high for cycle N..N+1 only.
- set_val sampled at edge N, visible on sts_val after edge N.
- Read issued at edge N: rd_data valid after edge N+Rlat-1 (Rlat=1: next cycle; Rlat=2: one extra register stage). rd_data holds last value when en=0.
- Back-to-back accesses every cycle supported; no stalls.
- irq registered: asserts one cycle after the sts_val bit appears.

## Configuration
- BRAM_REGFILE_IRQ_EN defined: irq = registered OR of all sts_val bits of all W1C registers.
- Undefined: no status-OR logic; irq tied to 0. All other behaviour identical.

## Structure
- Package bram_regfile_pkg: enum reg_mode_t {REG_RW, REG_RO, REG_W1C, REG_PULSE}, constant RDLAT_MAX = 2, default mode array helper.
- Sub-module bram_regfile_lane: one byte lane of one register (RW/W1C/PULSE update logic), instantiated via generate over Nregs x Nbyte.

## Test plan
- Reset with init_reg[1]=0x12345678 -> reg_val[1]=0x12345678, rd_data=0, pul_val=0, sts_val=0, irq=0.
- RW reg 1: write 0xAABBCCDD with we=4'b0101 -> reg_val[1]=0x12BB56DD; read returns it after Rlat cycles (test Rlat=1 and 2).
- PULSE reg 2: write 0x00000081 -> pul_val[2]=0x81 for exactly one cycle, then 0; read of reg 2 returns 0.
- W1C reg 3: set_val[3]=0x5 one cycle -> sts_val[3]=0x5, irq=1 next cycle (macro on); write 0x1 -> 0x4; same-cycle set bit 2 and clear 0x4 -> stays 0x4.
- RO reg 0 read_val=0xCAFEF00D: write 0xFFFFFFFF ignored, read returns 0xCAFEF00D; Nregs=12 read addr 14 -> 0.
- Assert resetn low during a Rlat=2 read -> rd_data=0 immediately, no stale data after release.
